// File: rtl/nios2_onchip_mem_pkg.sv
// Shared types, limits and helpers for the Nios II on-chip data memory.
package nios2_onchip_mem_pkg;

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   localparam int unsigned MAX_READ_LATENCY = 2;
   localparam int unsigned MIN_DATA_W       = 8;

   // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/nios2_onchip_mem_ram.sv
// Single-port RAM: per-lane synchronous write, registered read that can be forced to zero.
module nios2_onchip_mem_ram #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned LANE_W = 8,
   parameter int unsigned DEPTH  = 1860,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_en,
   input  logic [LANES-1:0]        i_we,
   input  logic                    i_rd,
   input  logic                    i_rd_zero,
   input  logic [AW-1:0]           i_addr,
   input  logic [LANES*LANE_W-1:0] i_wdata,
   output logic [LANES*LANE_W-1:0] o_rdata
);

   localparam int unsigned WORD_W = LANES * LANE_W;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_q;

   always_ff @(posedge clk) begin : p_write
      if (i_en) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (i_we[i]) r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   // Out-of-range reads load zero instead of touching the array.
   always_ff @(posedge clk or negedge rst_n) begin : p_read
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_en && i_rd) begin
         r_q <= i_rd_zero ? '0 : r_mem[i_addr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/nios2_system_onchip_mem_pipe.sv
// Avalon-MM on-chip RAM with post-reset zero fill, 1/2-cycle read latency and range check.
// Optional per-byte parity storage and sticky parity_err: define ONCHIP_MEM_PARITY_EN.
module nios2_system_onchip_mem_pipe
   import nios2_onchip_mem_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned DEPTH          = 1860,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned CLEAR_ON_RESET = 1,
   parameter string       INIT_FILE      = "nios2_system_onchip_mem.hex",
   localparam int unsigned AW            = $clog2(DEPTH),
   localparam int unsigned BE_W          = DATA_W / MIN_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [AW-1:0]     address,
   input  logic [BE_W-1:0]   byteenable,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   input  logic              clken,
   output logic              waitrequest,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid,
   output logic              oob_err
`ifdef ONCHIP_MEM_PARITY_EN
   ,
   output logic              parity_err
`endif
);

`ifdef ONCHIP_MEM_PARITY_EN
   localparam int unsigned LANE_W = MIN_DATA_W + 1;
`else
   localparam int unsigned LANE_W = MIN_DATA_W;
`endif
   localparam int unsigned WORD_W = BE_W * LANE_W;
   localparam int unsigned AW1    = AW + 1;
   localparam int unsigned RL     = (READ_LATENCY >= MAX_READ_LATENCY) ? MAX_READ_LATENCY : 1;
   // Without an image there is nothing to preserve, so the array is zero-filled.
   localparam bit          DO_CLEAR  = (CLEAR_ON_RESET != 0) || (INIT_FILE == "");
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t              r_state, w_state_nxt;
   logic [AW-1:0]       r_clr_cnt, w_clr_cnt_nxt;
   logic                w_run, w_acc, w_wr, w_rd, w_oob;
   logic [RL-1:0]       r_vld;
   logic                r_oob;
   logic [AW-1:0]       w_ram_addr;
   logic [BE_W-1:0]     w_ram_we;
   logic [WORD_W-1:0]   w_ram_wdata, w_ram_rdata;
   logic [DATA_W-1:0]   w_rd_data;
`ifdef ONCHIP_MEM_PARITY_EN
   logic                w_par_bad;
   logic                r_parity_err;
`endif

   always_comb begin : p_fsm_nxt
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      if (r_state == S_CLEAR && clken) begin
         if (r_clr_cnt == LAST_ADDR) w_state_nxt   = S_RUN;
         else                        w_clr_cnt_nxt = r_clr_cnt + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin : p_fsm_reg
      if (!reset_n) begin
         r_state   <= DO_CLEAR ? S_CLEAR : S_RUN;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   // A simultaneous read+write is a write only.
   assign w_run       = (r_state == S_RUN);
   assign w_oob       = ({1'b0, address} >= AW1'(DEPTH));
   assign w_acc       = w_run & chipselect & (read | write) & clken;
   assign w_wr        = w_acc & write;
   assign w_rd        = w_acc & read & ~write;
   assign waitrequest = ~w_run | ~clken;

   always_comb begin : p_ram_wr
      w_ram_addr  = address;
      w_ram_we    = '0;
      w_ram_wdata = '0;
      if (!w_run) begin
         w_ram_addr = r_clr_cnt;
         w_ram_we   = '1;
      end else begin
         if (w_wr && !w_oob) w_ram_we = byteenable;
         for (int unsigned i = 0; i < BE_W; i++) begin
`ifdef ONCHIP_MEM_PARITY_EN
            w_ram_wdata[i*LANE_W +: LANE_W] = {byte_parity(writedata[i*8 +: 8]), writedata[i*8 +: 8]};
`else
            w_ram_wdata[i*LANE_W +: LANE_W] = writedata[i*8 +: 8];
`endif
         end
      end
   end

   nios2_onchip_mem_ram #(
      .LANES  (BE_W),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk       (clk),
      .rst_n     (reset_n),
      .i_en      (clken),
      .i_we      (w_ram_we),
      .i_rd      (w_rd),
      .i_rd_zero (w_oob),
      .i_addr    (w_ram_addr),
      .i_wdata   (w_ram_wdata),
      .o_rdata   (w_ram_rdata)
   );

   always_comb begin : p_lanes
      w_rd_data = '0;
`ifdef ONCHIP_MEM_PARITY_EN
      w_par_bad = 1'b0;
`endif
      for (int unsigned i = 0; i < BE_W; i++) begin
         w_rd_data[i*8 +: 8] = w_ram_rdata[i*LANE_W +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
         if (byte_parity(w_ram_rdata[i*LANE_W +: 8]) != w_ram_rdata[i*LANE_W + 8]) w_par_bad = 1'b1;
`endif
      end
   end

   // r_vld[0] marks the RAM output register as holding the newest accepted read.
   always_ff @(posedge clk or negedge reset_n) begin : p_pipe
      if (!reset_n) begin
         r_vld <= '0;
         r_oob <= 1'b0;
      end else if (clken) begin
         r_vld <= RL'({r_vld, w_rd});
         r_oob <= w_acc & w_oob;
      end
   end

   assign readdatavalid = r_vld[RL-1];
   assign oob_err       = r_oob;

   generate
      if (RL == 1) begin : g_lat1
         assign readdata = w_rd_data;
      end else begin : g_lat2
         logic [DATA_W-1:0] r_rdata;
         always_ff @(posedge clk or negedge reset_n) begin : p_rdata
            if (!reset_n)   r_rdata <= '0;
            else if (clken) r_rdata <= w_rd_data;
         end
         assign readdata = r_rdata;
      end
   endgenerate

`ifdef ONCHIP_MEM_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin : p_parity
      if (!reset_n)                            r_parity_err <= 1'b0;
      else if (clken && r_vld[0] && w_par_bad) r_parity_err <= 1'b1;
   end
   assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_nios2_system_onchip_mem_pipe.sv
// Bench: latency-1 and latency-2 instances share one randomized stimulus, checked against a word-array model.
module tb_nios2_system_onchip_mem_pipe;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 1860;
   localparam int unsigned AW    = 11;
   localparam int unsigned BW    = 4;

   logic          clk = 1'b0;
   logic          reset_n, chipselect, read, write, clken;
   logic [AW-1:0] address;
   logic [BW-1:0] byteenable;
   logic [DW-1:0] writedata;
   logic          wr1, wr2, rdv1, rdv2, oob1, oob2;
   logic [DW-1:0] rd1, rd2;
`ifdef ONCHIP_MEM_PARITY_EN
   logic          pe1, pe2;
   int            par_ce;
   bit            corrupt7;
`endif

   always #5 clk = ~clk;

   nios2_system_onchip_mem_pipe #(
      .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .waitrequest(wr1), .readdata(rd1), .readdatavalid(rdv1),
      .oob_err(oob1)
`ifdef ONCHIP_MEM_PARITY_EN
      , .parity_err(pe1)
`endif
   );

   nios2_system_onchip_mem_pipe #(
      .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
   ) u_dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .waitrequest(wr2), .readdata(rd2), .readdatavalid(rdv2),
      .oob_err(oob2)
`ifdef ONCHIP_MEM_PARITY_EN
      , .parity_err(pe2)
`endif
   );

   typedef struct {
      int            ce;
      logic [DW-1:0] data;
   } rd_t;

   logic [DW-1:0] ref_mem [DEPTH];
   rd_t           rdq[$];
   int            ce;
   int            clear_left;
   int            oob_ce;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic          exp_wr, v1, v2;
      logic [DW-1:0] d1, d2;
      exp_wr = (clear_left > 0) || !clken;
      v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;
      foreach (rdq[i]) begin
         if (rdq[i].ce == ce)     begin v1 = 1'b1; d1 = rdq[i].data; end
         if (rdq[i].ce == ce - 1) begin v2 = 1'b1; d2 = rdq[i].data; end
      end
      chk("waitrequest_l1", wr1, exp_wr);
      chk("waitrequest_l2", wr2, exp_wr);
      chk("readdatavalid_l1", rdv1, v1);
      chk("readdatavalid_l2", rdv2, v2);
      if (v1) chk("readdata_l1", rd1, d1);
      if (v2) chk("readdata_l2", rd2, d2);
      chk("oob_err_l1", oob1, oob_ce == ce);
      chk("oob_err_l2", oob2, oob_ce == ce);
      if (!reset_n) begin
         chk("reset_readdata_l1", rd1, 0);
         chk("reset_readdata_l2", rd2, 0);
      end
`ifdef ONCHIP_MEM_PARITY_EN
      chk("parity_err_l1", pe1, (par_ce >= 0) && (ce > par_ce));
      chk("parity_err_l2", pe2, (par_ce >= 0) && (ce > par_ce));
`endif
   endtask

   // Reference behaviour of one clock edge: clear countdown, then Avalon accesses.
   task automatic model_edge();
      int a;
      if (!reset_n || !clken) return;
      ce++;
      while (rdq.size() > 0 && rdq[0].ce < ce - 2) void'(rdq.pop_front());
      if (clear_left > 0) begin
         clear_left--;
         return;
      end
      if (!(chipselect && (read || write))) return;
      a = int'(address);
      if (a >= int'(DEPTH)) oob_ce = ce;
      if (write) begin
         if (a < int'(DEPTH))
            for (int b = 0; b < int'(BW); b++)
               if (byteenable[b]) ref_mem[a][b*8 +: 8] = writedata[b*8 +: 8];
      end else begin
         rdq.push_back('{ce: ce, data: (a < int'(DEPTH)) ? ref_mem[a] : '0});
`ifdef ONCHIP_MEM_PARITY_EN
         if (a == 7 && corrupt7 && par_ce < 0) par_ce = ce;
`endif
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
   endtask

   task automatic flush(input int n);
      idle();
      repeat (n) tick();
   endtask

   task automatic access(input bit w, input int a, input logic [BW-1:0] be, input logic [DW-1:0] d);
      chipselect = 1'b1; read = !w; write = w; clken = 1'b1;
      address = AW'(a); byteenable = be; writedata = d;
      tick();
      idle();
   endtask

   task automatic enter_reset();
      reset_n    = 1'b0;
      clear_left = DEPTH;
      oob_ce     = -100;
      rdq.delete();
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
`ifdef ONCHIP_MEM_PARITY_EN
      par_ce   = -1;
      corrupt7 = 1'b0;
`endif
   endtask

   initial begin
      ce = 0;
      address = '0; byteenable = '0; writedata = '0;
      idle();
      enter_reset();
      repeat (3) tick();
      reset_n = 1'b1;

      // Zero fill: waitrequest for DEPTH cycles, then top word reads back zero.
      flush(DEPTH + 2);
      access(0, DEPTH - 1, '0, '0);
      access(0, 0, '0, '0);
      flush(3);

      // Byte-lane merge and the byteenable=0 no-op.
      access(1, 5, 4'hF, 32'h1122_3344);
      access(1, 5, 4'b0101, 32'hDEAD_BEEF);
      access(0, 5, '0, '0);
      access(1, 5, 4'h0, 32'hFFFF_FFFF);
      access(0, 5, '0, '0);
      flush(3);

      // Back-to-back reads keep order.
      for (int i = 0; i < 3; i++) access(1, i, 4'hF, $urandom);
      for (int i = 0; i < 3; i++) access(0, i, '0, '0);
      flush(4);

      // Out-of-range write/read, neighbours untouched.
      access(1, DEPTH, 4'hF, 32'hCAFE_F00D);
      flush(1);
      access(0, DEPTH, '0, '0);
      flush(1);
      access(0, 0, '0, '0);
      access(0, DEPTH - 1, '0, '0);
      flush(4);

      // Read held across a clken stall, then read-after-write on the next cycle.
      access(0, 3, '0, '0);
      clken = 1'b0;
      repeat (3) tick();
      flush(3);
      access(1, 9, 4'hF, 32'h5A5A_A5A5);
      access(0, 9, '0, '0);
      flush(3);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         int sel;
         clken      = ($urandom_range(0, 9) != 0);
         chipselect = ($urandom_range(0, 7) != 0);
         read       = 1'($urandom_range(0, 1));
         write      = ($urandom_range(0, 2) == 0);
         sel        = int'($urandom_range(0, 9));
         if (sel < 7)      address = AW'($urandom_range(0, 15));
         else if (sel < 9) address = AW'($urandom_range(DEPTH - 4, DEPTH - 1));
         else              address = AW'($urandom_range(DEPTH, 2047));
         byteenable = BW'($urandom);
         writedata  = $urandom;
         tick();
      end
      flush(4);

`ifdef ONCHIP_MEM_PARITY_EN
      // Corrupt one stored bit of word 7; parity_err must latch and hold.
      access(1, 7, 4'hF, 32'h0F0F_1234);
      flush(2);
      u_dut1.u_ram.r_mem[7][0] = ~u_dut1.u_ram.r_mem[7][0];
      u_dut2.u_ram.r_mem[7][0] = ~u_dut2.u_ram.r_mem[7][0];
      ref_mem[7][0] = ~ref_mem[7][0];
      corrupt7 = 1'b1;
      access(0, 7, '0, '0);
      flush(10);
`endif

      // Reset at clear count 100 restarts the full fill.
      enter_reset();
      repeat (3) tick();
      reset_n = 1'b1;
      flush(100);
      enter_reset();
      repeat (2) tick();
      reset_n = 1'b1;
      flush(DEPTH + 2);
      access(0, DEPTH - 1, '0, '0);
      access(0, 5, '0, '0);
      flush(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
